// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Op encodings, FSM state encoding and the iteration counter width helper.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_DIVU = 2'b01,
        OP_MULS = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    // Iteration counter width: $clog2(WIDTH), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
// The accumulator holds {upper, lower}; lower is the multiplier or the dividend/quotient.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   top_c;
    logic [WIDTH+1:0] diff_c;

    always_comb begin
        // Multiply: add multiplicand when the low multiplier bit is set, carry kept in bit WIDTH.
        sum_c  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
               + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        // Divide: shifted partial remainder needs WIDTH+1 bits, subtract one wider for the borrow.
        top_c  = acc_i[2*WIDTH-1:WIDTH-1];
        diff_c = {1'b0, top_c} - {2'b00, opnd_i};
        acc_o  = {sum_c, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (diff_c[WIDTH+1]) begin
                acc_o = {top_c[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff_c[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit with start/busy/done handshake.
// Define MULDIV_SIGNED_EN to add signed ops (op[1]) and the FIXUP sign-correction cycle.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              div_by_zero
);

    localparam int unsigned       CNT_W = cnt_width(WIDTH);
    localparam int unsigned       ACC_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [WIDTH-1:0]    opnd_q;
    logic                is_div_q;
    logic [WIDTH-1:0]    hi_q;
    logic [WIDTH-1:0]    lo_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_q;
`ifdef MULDIV_SIGNED_EN
    logic                signed_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic                a_neg_c;
    logic                b_neg_c;
`endif

    logic                is_div_c;
    logic [WIDTH-1:0]    a_mag_c;
    logic [WIDTH-1:0]    b_mag_c;

    // Operand conditioning at launch: magnitudes for signed ops, raw values otherwise.
    always_comb begin
        is_div_c = (op_e'(op) == OP_DIVU) || (op_e'(op) == OP_DIVS);
`ifdef MULDIV_SIGNED_EN
        a_neg_c  = op[1] & a[WIDTH-1];
        b_neg_c  = op[1] & b[WIDTH-1];
        a_mag_c  = a_neg_c ? (~a + WIDTH'(1)) : a;
        b_mag_c  = b_neg_c ? (~b + WIDTH'(1)) : b;
`else
        a_mag_c  = a;
        b_mag_c  = b;
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            signed_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (start) begin
                        dbz_q    <= 1'b0;
                        is_div_q <= is_div_c;
                        cnt_q    <= '0;
                        opnd_q   <= is_div_c ? b_mag_c : a_mag_c;
                        acc_q    <= {{WIDTH{1'b0}}, (is_div_c ? a_mag_c : b_mag_c)};
`ifdef MULDIV_SIGNED_EN
                        signed_q  <= op[1];
                        neg_res_q <= a_neg_c ^ b_neg_c;
                        neg_rem_q <= a_neg_c;
`endif
                        // Divide by zero bypasses the iteration entirely.
                        if (is_div_c && (b == '0)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            lo_q    <= '1;
                            hi_q    <= a;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
`ifdef MULDIV_SIGNED_EN
                        if (signed_q) begin
                            state_q <= S_FIXUP;
                        end else
`endif
                        begin
                            state_q      <= S_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            {hi_q, lo_q} <= acc_d;
                        end
                    end
                end
`ifdef MULDIV_SIGNED_EN
                S_FIXUP: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    // Quotient/product take sign(a)^sign(b); remainder follows the dividend.
                    if (is_div_q) begin
                        lo_q <= neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
                        hi_q <= neg_rem_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1))
                                          : acc_q[ACC_W-1:WIDTH];
                    end else begin
                        {hi_q, lo_q} <= neg_res_q ? (~acc_q + ACC_W'(1)) : acc_q;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed steps plus randomized ops vs. an arithmetic model.
// Expected signed behaviour follows MULDIV_SIGNED_EN when it is defined for the build.
module tb_mul_div_unit;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] ehi, output logic [W-1:0] elo,
                                  output logic edbz, output int elat);
        logic        sgn;
        int          sx;
        int          sy;
        int          q;
        int          r;
        int          ps;
        logic [31:0] pu;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = o[1];
`endif
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        edbz = 1'b0;
        elat = sgn ? 18 : 17;
        if (o[0]) begin
            if (y == '0) begin
                elo = '1; ehi = x; edbz = 1'b1; elat = 1;
            end else if (sgn) begin
                q = sx / sy; r = sx % sy;
                elo = q[W-1:0]; ehi = r[W-1:0];
            end else begin
                elo = x / y; ehi = x % y;
            end
        end else if (sgn) begin
            ps = sx * sy;
            {ehi, elo} = ps;
        end else begin
            pu = {16'h0, x} * {16'h0, y};
            {ehi, elo} = pu;
        end
    endfunction

    // Called at a negedge; start is sampled at the following posedge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int k;
        int nbusy;
        k = 0; nbusy = 0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) break;
            if (busy === 1'b1) nbusy++;
        end
        check({tag, " latency"}, k, exp_lat);
        check({tag, " busy cycles"}, nbusy, exp_lat - 1);
        check({tag, " busy at done"}, busy, 0);
    endtask

    task automatic finish_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y);
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edbz;
        int           elat;
        model(o, x, y, ehi, elo, edbz, elat);
        wait_done(tag, elat);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        check({tag, " dbz"}, div_by_zero, edbz);
        last_hi = ehi;
        last_lo = elo;
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        launch(o, x, y);
        finish_op(tag, o, x, y);
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset dbz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        do_op("mulu 1234x5678", 2'b00, 16'h1234, 16'h5678);
        check("mulu 1234x5678 hi const", hi, 16'h0626);
        check("mulu 1234x5678 lo const", lo, 16'h0060);
        @(negedge clk);
        check("done single pulse", done, 0);
        check("idle after done", busy, 0);

        // Back-to-back: each launch happens in the previous op's DONE cycle.
        do_op("mulu ffffxffff", 2'b00, 16'hFFFF, 16'hFFFF);
        check("mulu ffff hi const", hi, 16'hFFFE);
        check("mulu ffff lo const", lo, 16'h0001);
        do_op("divu 100/7", 2'b01, 16'd100, 16'd7);
        check("divu 100/7 lo const", lo, 16'h000E);
        check("divu 100/7 hi const", hi, 16'h0002);
        do_op("divu by zero", 2'b01, 16'h0042, 16'h0000);
        check("dbz lo const", lo, 16'hFFFF);
        check("dbz hi const", hi, 16'h0042);
        launch(2'b00, 16'd3, 16'd5);
        check("dbz cleared on start", div_by_zero, 0);
        finish_op("mulu 3x5", 2'b00, 16'd3, 16'd5);

        // Start pulsed during RUN with different operands must be ignored.
        launch(2'b00, 16'h00FF, 16'h0101);
        fork
            begin
                repeat (3) @(negedge clk);
                op = 2'b01; a = 16'h0009; b = 16'h0003; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            finish_op("mulu ignore start", 2'b00, 16'h00FF, 16'h0101);
        join

        // Flush at RUN cycle 5 together with start: flush wins, result never lands.
        @(negedge clk);
        launch(2'b00, 16'h1111, 16'h2222);
        repeat (5) @(negedge clk);
        check("flush busy before", busy, 1);
        flush = 1'b1; start = 1'b1; op = 2'b01; a = 16'h0010; b = 16'h0002;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush busy", busy, 0);
        check("flush done", done, 0);
        check("flush hi held", hi, last_hi);
        check("flush lo held", lo, last_lo);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("flush no done", ndone, 0);

        // Async reset mid-RUN clears everything immediately.
        launch(2'b00, 16'hABCD, 16'h0123);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun reset busy", busy, 0);
        check("midrun reset done", done, 0);
        check("midrun reset hi", hi, 0);
        check("midrun reset lo", lo, 0);
        check("midrun reset dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op("mulu after reset", 2'b00, 16'd7, 16'd9);

        do_op("divs fff9/2", 2'b11, 16'hFFF9, 16'h0002);
`ifdef MULDIV_SIGNED_EN
        check("divs lo const", lo, 16'hFFFD);
        check("divs hi const", hi, 16'hFFFF);
`else
        check("divs lo const", lo, 16'h7FFC);
        check("divs hi const", hi, 16'h0001);
`endif
        do_op("divs overflow", 2'b11, 16'h8000, 16'hFFFF);
        do_op("muls min x min", 2'b10, 16'h8000, 16'h8000);
        do_op("divs by zero", 2'b11, 16'h8001, 16'h0000);
        do_op("divu ffff/1", 2'b01, 16'hFFFF, 16'h0001);
        do_op("mulu zero", 2'b00, 16'h0000, 16'h1234);

        for (int i = 0; i < 30; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            ro = 2'($urandom);
            rx = W'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op($sformatf("rand%0d op%0d", i, ro), ro, rx, ry);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
